ecc_result_serializer: RTL and testbench
========================================

Name: ecc_result_serializer

Overview:
- Downstream stage of the 64-bit ECC point-multiplication core.
- Captures the result point (x, y) when the core's done flag rises and streams it out as narrow beats over a valid/ready interface, for the host/UART bridge.
- Decouples the core from a slow consumer: the core may re-arm and compute again while a frame is draining. A new result arriving mid-frame is flagged, not queued.

Parameters:
- DATA_W, 64: width of each coordinate.
- OUT_W, 8: width of one output beat. Constraints: OUT_W <= DATA_W, and DATA_W divisible by OUT_W.
- BEATS, 2*DATA_W/OUT_W (derived localparam, 16 at defaults): beats per frame.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- done_in  input  1  core completion flag (level; held high while core sits in its DONE state).
- x_in  input  DATA_W  core result x; valid whenever done_in=1.
- y_in  input  DATA_W  core result y; valid whenever done_in=1.
- out_data  output  OUT_W  current beat.
- out_valid  output  1  beat valid.
- out_ready  input  1  consumer ready; a beat transfers when out_valid & out_ready.
- out_last  output  1  high with the final beat (index BEATS-1) of a frame.
- busy  output  1  frame in progress (state SEND).
- overrun_err  output  1  sticky; a result was dropped.
- frame_cnt  output  16  completed frames, wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; done_q=0; shift buffer=0; beat_cnt=0. Outputs: out_data=0, out_valid=0, out_last=0, busy=0, overrun_err=0, frame_cnt=0. Reset mid-frame abandons the frame with no partial completion; frame_cnt is not incremented.
- Edge detect: done_q <= done_in every cycle. rise = done_in & ~done_q. Because done_q resets to 0, done_in already high on the first post-reset cycle counts as a rise.
- State IDLE:
  - On rise: load buffer = {y_in, x_in}; beat_cnt=0; go to SEND.
  - out_valid=1 from the next cycle. Latency is rise cycle N -> first beat valid in cycle N+1.
- State SEND:
  - out_data = buffer[OUT_W-1:0]. Beat order is x LS byte first, through x MS, then y LS through y MS.
  - out_last = (beat_cnt == BEATS-1).
  - On transfer: buffer shifts right by OUT_W, zero-fill; beat_cnt increments.
  - Transfer with out_last=1: go to IDLE; out_valid=0 next cycle; frame_cnt += 1.
  - While out_valid & ~out_ready: out_data, out_last and beat_cnt are held stable. Valid is never withdrawn once asserted.
- Back-to-back frames: a rise in IDLE the cycle after the last transfer is accepted, giving one idle cycle between frames. A rise in the same cycle as the last transfer is in SEND and is therefore an overrun.
- Overrun: a rise while in SEND sets overrun_err=1 (sticky until rst). The new result is discarded and the current frame continues unaffected.
- Level held: done_in staying high produces no further capture. The core must drop done_in (re-arm) before the next result is taken.
- busy = (state == SEND). out_valid == busy.
- beat_cnt width is clog2(BEATS). No wrap occurs within a frame.

Test Plan:
1. Reset, then done_in 0->1 with x=0x1234567890ABCDEF, y=0xFEDCBA0987654321, out_ready=1 -> out_valid high in the cycle after the rise. 16 beats: EF,CD,AB,90,78,56,34,12,21,43,65,87,09,BA,DC,FE. out_last only on FE. frame_cnt=1, busy=0 after.
2. Same frame with out_ready toggling 1,0,0,1,... -> no beat lost or duplicated, out_data stable while stalled, sequence identical to test 1.
3. Second done_in rise at beat 5 with x=y=0xFFFF...F -> overrun_err=1 and stays 1. Frame still emits the original 16 bytes. No second frame follows.
4. done_in held high for 40 cycles after frame completes -> exactly one frame, frame_cnt=1. Drop done_in, raise again with x=0x0, y=0x1 -> second frame 00 x8, 01, 00 x7, frame_cnt=2.
5. rst=1 at beat 9 -> next cycle: out_valid=0, busy=0, frame_cnt unchanged (0), overrun_err=0. A later rise starts a full fresh frame from beat 0.
6. done_in=1 while rst deasserts -> capture on first post-reset cycle, valid in the following cycle. Also preload frame_cnt to 0xFFFF via 65535 frames (or a forced value in the bench) and complete one more frame -> frame_cnt=0x0000.

Source files
------------

// File: rtl/ecc_result_serializer.sv
// ecc_result_serializer
// Captures the (x, y) result of the ECC point-multiplication core on the
// rising edge of its done flag and streams it out as OUT_W-bit beats over a
// valid/ready link. Beat order: x LS slice first through x MS, then y LS
// through y MS. A result that arrives while a frame is still draining is
// dropped and flagged in a sticky overrun bit.
// OUT_W must not exceed DATA_W, and DATA_W must be a multiple of OUT_W.
module ecc_result_serializer #(
    parameter int DATA_W = 64,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_in,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] y_in,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              overrun_err,
    output logic [15:0]       frame_cnt
);

    localparam int BEATS = 2 * DATA_W / OUT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int BUF_W = 2 * DATA_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic               done_q_reg;
    logic [BUF_W-1:0]   frame_buf_reg, frame_buf_next;
    logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic               overrun_reg, overrun_next;
    logic [15:0]        frame_cnt_reg, frame_cnt_next;

    logic               rise;
    logic               is_last;
    logic               xfer;
    logic [BUF_W-1:0]   frame_buf_shifted;

    // Buffer advanced by one beat: each slice takes its upper neighbour and
    // the top slice is zero-filled.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_shift
            if (gi < BEATS - 1) begin : g_move
                assign frame_buf_shifted[gi*OUT_W +: OUT_W] =
                    frame_buf_reg[(gi+1)*OUT_W +: OUT_W];
            end else begin : g_fill
                assign frame_buf_shifted[gi*OUT_W +: OUT_W] = '0;
            end
        end
    endgenerate

    assign rise    = done_in & ~done_q_reg;
    assign busy    = (state_reg == SEND);
    assign is_last = busy && (beat_cnt_reg == LAST_IDX);
    assign xfer    = busy && out_ready;

    assign out_valid   = busy;
    assign out_last    = is_last;
    assign out_data    = frame_buf_reg[OUT_W-1:0];
    assign overrun_err = overrun_reg;
    assign frame_cnt   = frame_cnt_reg;

    // Next-state logic: capture on a done rise in IDLE, shift on each
    // accepted beat in SEND, flag any rise that lands mid-frame.
    always_comb begin
        state_next     = state_reg;
        frame_buf_next = frame_buf_reg;
        beat_cnt_next  = beat_cnt_reg;
        overrun_next   = overrun_reg;
        frame_cnt_next = frame_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (rise) begin
                    frame_buf_next = {y_in, x_in};
                    beat_cnt_next  = '0;
                    state_next     = SEND;
                end
            end
            SEND: begin
                if (rise) begin
                    overrun_next = 1'b1;
                end
                if (xfer) begin
                    frame_buf_next = frame_buf_shifted;
                    if (is_last) begin
                        beat_cnt_next  = '0;
                        state_next     = IDLE;
                        frame_cnt_next = frame_cnt_reg + 16'd1;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            done_q_reg    <= 1'b0;
            frame_buf_reg <= '0;
            beat_cnt_reg  <= '0;
            overrun_reg   <= 1'b0;
            frame_cnt_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            done_q_reg    <= done_in;
            frame_buf_reg <= frame_buf_next;
            beat_cnt_reg  <= beat_cnt_next;
            overrun_reg   <= overrun_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

endmodule

// File: tb/tb_ecc_result_serializer.sv
// Scoreboard bench for ecc_result_serializer: expected beats are queued when
// a capture is triggered and checked as the DUT hands them over.
module tb_ecc_result_serializer;

    logic        clk;
    logic        rst;
    logic        done_in;
    logic [63:0] x_in;
    logic [63:0] y_in;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        overrun_err;
    logic [15:0] frame_cnt;

    int total;
    int bad;
    int beats_seen;
    int ready_mode;
    int ready_phase;
    int exp_frames;
    logic [8:0] sb_q[$];

    ecc_result_serializer #(.DATA_W(64), .OUT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .done_in     (done_in),
        .x_in        (x_in),
        .y_in        (y_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .overrun_err (overrun_err),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beats: x bytes LS first, then y bytes LS first; last on 16th.
    task automatic push_frame(input logic [63:0] x, input logic [63:0] y);
        logic [127:0] w;
        w = {y, x};
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back({(i == 15), w[i*8 +: 8]});
        end
    endtask

    task automatic raise_done(input logic [63:0] x, input logic [63:0] y);
        x_in    = x;
        y_in    = y;
        done_in = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain_timeout", {63'd0, (n >= budget)}, 64'd0);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n;
        n = 0;
        while (beats_seen < target && n < budget) begin
            tick();
            n++;
        end
        check_eq("beat_wait_timeout", {63'd0, (n >= budget)}, 64'd0);
    endtask

    // Consumer ready: constantly high, or the repeating 1,0,0 pattern.
    initial begin
        out_ready   = 1'b1;
        ready_phase = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                out_ready = 1'b1;
            end else begin
                out_ready   = (ready_phase == 0);
                ready_phase = (ready_phase == 2) ? 0 : ready_phase + 1;
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check_eq("valid_eq_busy", {63'd0, out_valid}, {63'd0, busy});
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        check_eq("spurious_valid", {63'd0, out_valid}, 64'd0);
                    end else if (out_ready) begin
                        check_eq("beat_data", {56'd0, out_data}, {56'd0, sb_q[0][7:0]});
                        check_eq("beat_last", {63'd0, out_last}, {63'd0, sb_q[0][8]});
                        $display("beat %0d data=%02h last=%0b", beats_seen, out_data, out_last);
                        void'(sb_q.pop_front());
                        beats_seen++;
                    end else begin
                        check_eq("stall_data", {56'd0, out_data}, {56'd0, sb_q[0][7:0]});
                        check_eq("stall_last", {63'd0, out_last}, {63'd0, sb_q[0][8]});
                    end
                end else begin
                    check_eq("last_idle", {63'd0, out_last}, 64'd0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "global timeout");
    end

    initial begin
        total      = 0;
        bad        = 0;
        beats_seen = 0;
        ready_mode = 0;
        exp_frames = 0;
        rst        = 1'b1;
        done_in    = 1'b0;
        x_in       = '0;
        y_in       = '0;
        tick();
        tick();
        check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_last", {63'd0, out_last}, 64'd0);
        check_eq("rst_data", {56'd0, out_data}, 64'd0);
        check_eq("rst_overrun", {63'd0, overrun_err}, 64'd0);
        check_eq("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
        rst = 1'b0;
        tick();

        // 1: basic frame, ready always high, latency check.
        raise_done(64'h1234567890ABCDEF, 64'hFEDCBA0987654321);
        push_frame(64'h1234567890ABCDEF, 64'hFEDCBA0987654321);
        check_eq("t1_valid_rise_cycle", {63'd0, out_valid}, 64'd0);
        tick();
        check_eq("t1_valid_next_cycle", {63'd0, out_valid}, 64'd1);
        wait_drain(100);
        exp_frames++;
        check_eq("t1_frame_cnt", {48'd0, frame_cnt}, exp_frames);
        check_eq("t1_busy_after", {63'd0, busy}, 64'd0);
        $display("frame 1 complete frame_cnt=%0d", frame_cnt);

        // 2: same frame with a stalling consumer.
        done_in = 1'b0;
        tick();
        ready_mode = 1;
        raise_done(64'h1234567890ABCDEF, 64'hFEDCBA0987654321);
        push_frame(64'h1234567890ABCDEF, 64'hFEDCBA0987654321);
        tick();
        wait_drain(200);
        exp_frames++;
        check_eq("t2_frame_cnt", {48'd0, frame_cnt}, exp_frames);
        ready_mode = 0;
        $display("frame 2 complete frame_cnt=%0d", frame_cnt);

        // 3: second rise mid-frame is an overrun, frame continues intact.
        done_in = 1'b0;
        tick();
        raise_done(64'h1234567890ABCDEF, 64'hFEDCBA0987654321);
        push_frame(64'h1234567890ABCDEF, 64'hFEDCBA0987654321);
        wait_beats(beats_seen + 5, 100);
        done_in = 1'b0;
        tick();
        raise_done(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check_eq("t3_overrun_set", {63'd0, overrun_err}, 64'd1);
        wait_drain(100);
        exp_frames++;
        repeat (20) tick();
        check_eq("t3_overrun_sticky", {63'd0, overrun_err}, 64'd1);
        check_eq("t3_no_second_frame", {63'd0, busy}, 64'd0);
        check_eq("t3_frame_cnt", {48'd0, frame_cnt}, exp_frames);
        $display("frame 3 complete with overrun frame_cnt=%0d", frame_cnt);

        // 4: level held high gives a single frame; re-arm for the next.
        done_in = 1'b0;
        tick();
        raise_done(64'h1234567890ABCDEF, 64'hFEDCBA0987654321);
        push_frame(64'h1234567890ABCDEF, 64'hFEDCBA0987654321);
        wait_drain(100);
        exp_frames++;
        repeat (40) tick();
        check_eq("t4_held_frame_cnt", {48'd0, frame_cnt}, exp_frames);
        check_eq("t4_held_busy", {63'd0, busy}, 64'd0);
        done_in = 1'b0;
        tick();
        raise_done(64'h0, 64'h1);
        push_frame(64'h0, 64'h1);
        wait_drain(100);
        exp_frames++;
        check_eq("t4_second_frame_cnt", {48'd0, frame_cnt}, exp_frames);
        $display("frame 4b complete frame_cnt=%0d", frame_cnt);

        // 5: reset mid-frame abandons it; next rise starts fresh.
        done_in = 1'b0;
        tick();
        raise_done(64'h1234567890ABCDEF, 64'hFEDCBA0987654321);
        push_frame(64'h1234567890ABCDEF, 64'hFEDCBA0987654321);
        wait_beats(beats_seen + 9, 100);
        rst     = 1'b1;
        done_in = 1'b0;
        sb_q.delete();
        tick();
        exp_frames = 0;
        check_eq("t5_valid", {63'd0, out_valid}, 64'd0);
        check_eq("t5_busy", {63'd0, busy}, 64'd0);
        check_eq("t5_frame_cnt", {48'd0, frame_cnt}, exp_frames);
        check_eq("t5_overrun", {63'd0, overrun_err}, 64'd0);
        rst = 1'b0;
        tick();
        raise_done(64'hA5A5_0F0F_3C3C_9669, 64'h0102_0304_0506_0708);
        push_frame(64'hA5A5_0F0F_3C3C_9669, 64'h0102_0304_0506_0708);
        wait_drain(100);
        exp_frames++;
        check_eq("t5_fresh_frame_cnt", {48'd0, frame_cnt}, exp_frames);
        $display("frame 5 complete after reset frame_cnt=%0d", frame_cnt);

        // 6: done_in already high as reset releases counts as a rise.
        rst = 1'b1;
        raise_done(64'h1234567890ABCDEF, 64'hFEDCBA0987654321);
        tick();
        rst        = 1'b0;
        exp_frames = 0;
        push_frame(64'h1234567890ABCDEF, 64'hFEDCBA0987654321);
        check_eq("t6_valid_capture_cycle", {63'd0, out_valid}, 64'd0);
        tick();
        check_eq("t6_valid_after_capture", {63'd0, out_valid}, 64'd1);
        wait_drain(100);
        exp_frames++;
        check_eq("t6_frame_cnt", {48'd0, frame_cnt}, exp_frames);

        // 6b: frame counter wraps from 0xFFFF to 0.
        done_in = 1'b0;
        tick();
        force dut.frame_cnt_reg = 16'hFFFF;
        tick();
        release dut.frame_cnt_reg;
        tick();
        check_eq("t6_preload", {48'd0, frame_cnt}, 64'hFFFF);
        raise_done(64'h0, 64'h1);
        push_frame(64'h0, 64'h1);
        wait_drain(100);
        check_eq("t6_wrap", {48'd0, frame_cnt}, 64'h0);
        $display("frame 6b complete frame_cnt=%0d", frame_cnt);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
